// File: rtl/intdiv_abs_seq.sv
// intdiv_abs_seq: digit-serial SD2 absolute value and sign of a redundant remainder, MSD first
module intdiv_abs_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   ps,
  input  logic [N-1:0]   tr,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] res,
  output logic [1:0]     sign
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] POS1 = 2'b10, NEG1 = 2'b01, ZERO_1 = 2'b00;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] ps_q, tr_q;
  logic [CW-1:0] cnt;
  logic [1:0] d, dn, dig, sign_nx;
  logic accept, last;
  always_comb begin
    accept = (state != RUN) && start;
    last = cnt == '0;
    d = {ps_q[cnt], tr_q[cnt]};
    // both redundant zeros collapse to ZERO_1 so 2'b11 never reaches res/sign
    dn = (d[1] ^ d[0]) ? d : ZERO_1;
    dig = (sign == ZERO_1) ? ((dn != ZERO_1) ? POS1 : ZERO_1) :
          (sign == POS1) ? dn : {dn[0], dn[1]};
    sign_nx = (sign == ZERO_1) ? dn : sign;
    state_nx = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ps_q <= '0;
      tr_q <= '0;
      cnt <= '0;
      res <= '0;
      sign <= ZERO_1;
    end else begin
      state <= state_nx;
      if (accept) begin
        ps_q <= ps;
        tr_q <= tr;
        cnt <= CW'(N - 1);
        res <= '0;
        sign <= ZERO_1;
      end else if (state == RUN) begin
        res[{cnt, 1'b0} +: 2] <= dig;
        sign <= sign_nx;
        cnt <= last ? cnt : cnt - 1'b1;
      end
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule

// File: tb/tb_intdiv_abs_seq.sv
// tb_intdiv_abs_seq: directed-vector bench for the digit-serial SD2 abs/sign controller
module tb_intdiv_abs_seq;
  logic clk = 0, rst_n = 0, start = 0;
  logic [7:0] ps = 0, tr = 0;
  logic busy, done;
  logic [15:0] res;
  logic [1:0] sign;
  int total = 0, bad = 0;

  intdiv_abs_seq #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ps(ps), .tr(tr),
    .busy(busy), .done(done), .res(res), .sign(sign)
  );

  always #5 clk = ~clk;

  // operand table with hand-derived |value| in SD2 and operand sign
  logic [7:0]  vp [8] = '{8'h40, 8'h20, 8'h01, 8'hF0, 8'hFF, 8'h00, 8'h80, 8'h00};
  logic [7:0]  vt [8] = '{8'h20, 8'h40, 8'h80, 8'hF0, 8'h00, 8'hFF, 8'h40, 8'h01};
  logic [15:0] vr [8] = '{16'h2400, 16'h2400, 16'h8001, 16'h0000, 16'hAAAA, 16'hAAAA, 16'h9000, 16'h0002};
  logic [1:0]  vs [8] = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01};

  task automatic test_reset;
    rst_n = 0; start = 1; ps = 8'h40; tr = 8'h20;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 0 || done !== 0 || res !== 16'h0 || sign !== 2'b00) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b res=%h sign=%b, want 0 0 0000 00", busy, done, res, sign);
    end
    start = 0; rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_timing;
    @(negedge clk); start = 1; ps = 8'h40; tr = 8'h20;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); start = 0;
      total++;
      if (busy !== 1 || done !== 0) begin
        bad++;
        $display("FAIL timing_run cycle %0d: busy=%b done=%b, want 1 0", k, busy, done);
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 0 || done !== 1 || res !== 16'h2400 || sign !== 2'b10) begin
      bad++;
      $display("FAIL timing_done: busy=%b done=%b res=%h sign=%b, want 0 1 2400 10", busy, done, res, sign);
    end
    @(negedge clk);
    total++;
    if (done !== 0 || busy !== 0 || res !== 16'h2400 || sign !== 2'b10) begin
      bad++;
      $display("FAIL timing_hold: busy=%b done=%b res=%h sign=%b, want 0 0 2400 10", busy, done, res, sign);
    end
  endtask

  task automatic test_values;
    for (int i = 0; i < 8; i++) begin
      bit seen = 0;
      @(negedge clk); start = 1; ps = vp[i]; tr = vt[i];
      @(negedge clk); start = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      total++;
      if (!seen || res !== vr[i] || sign !== vs[i]) begin
        bad++;
        $display("FAIL value[%0d] ps=%h tr=%h: done_seen=%b res=%h sign=%b, want res=%h sign=%b",
                 i, vp[i], vt[i], seen, res, sign, vr[i], vs[i]);
      end
    end
  endtask

  task automatic test_start_ignored;
    int ndone = 0;
    logic [15:0] r = 0;
    logic [1:0] s = 0;
    @(negedge clk); start = 1; ps = 8'h01; tr = 8'h80;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 5);
      ps = (c == 3 || c == 5) ? 8'hFF : 8'h01;
      tr = 8'h00;
      if (done) begin ndone++; r = res; s = sign; end
    end
    start = 0;
    total++;
    if (ndone !== 1 || r !== 16'h8001 || s !== 2'b01) begin
      bad++;
      $display("FAIL start_ignored: dones=%0d res=%h sign=%b, want 1 8001 01", ndone, r, s);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] bp [3] = '{8'h40, 8'h00, 8'h01};
    logic [7:0] bt [3] = '{8'h20, 8'hFF, 8'h80};
    logic [15:0] br [3] = '{16'h2400, 16'hAAAA, 16'h8001};
    logic [1:0] bs [3] = '{2'b10, 2'b01, 2'b01};
    int k = 0, last = 0;
    bit chk_clear = 1;
    @(negedge clk); start = 1; ps = bp[0]; tr = bt[0];
    for (int c = 1; c <= 40 && k < 3; c++) begin
      @(negedge clk);
      if (chk_clear) begin
        chk_clear = 0;
        total++;
        if (res !== 16'h0 || sign !== 2'b00 || busy !== 1) begin
          bad++;
          $display("FAIL b2b_clear[%0d]: busy=%b res=%h sign=%b, want 1 0000 00", k, busy, res, sign);
        end
      end
      if (busy && done) begin
        bad++;
        $display("FAIL b2b_overlap cycle %0d: busy and done both high", c);
      end
      if (done) begin
        total++;
        if (res !== br[k] || sign !== bs[k] || (k == 0 ? c : c - last) !== 9) begin
          bad++;
          $display("FAIL b2b_result[%0d]: res=%h sign=%b gap=%0d, want %h %b 9",
                   k, res, sign, k == 0 ? c : c - last, br[k], bs[k]);
        end
        last = c;
        k++;
        if (k < 3) begin ps = bp[k]; tr = bt[k]; chk_clear = 1; end
        else start = 0;
      end
    end
    start = 0;
    total++;
    if (k !== 3) begin
      bad++;
      $display("FAIL b2b_count: dones=%0d, want 3", k);
    end
  endtask

  task automatic test_reset_abort;
    int ndone = 0;
    bit seen = 0;
    @(negedge clk); start = 1; ps = 8'h40; tr = 8'h20;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); start = 0;
    end
    rst_n = 0;
    @(negedge clk); rst_n = 1;
    total++;
    if (busy !== 0 || done !== 0 || res !== 16'h0 || sign !== 2'b00) begin
      bad++;
      $display("FAIL abort_state: busy=%b done=%b res=%h sign=%b, want 0 0 0000 00", busy, done, res, sign);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL abort_no_done: dones=%0d, want 0", ndone);
    end
    @(negedge clk); start = 1; ps = 8'h20; tr = 8'h40;
    @(negedge clk); start = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    total++;
    if (!seen || res !== 16'h2400 || sign !== 2'b01) begin
      bad++;
      $display("FAIL abort_recover: done_seen=%b res=%h sign=%b, want 1 2400 01", seen, res, sign);
    end
  endtask

  initial begin
    test_reset;
    test_timing;
    test_values;
    test_start_ignored;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
